// File: rtl/ula_seq_unit.sv
// Sequential ULA: single-cycle ADD/SUB/logic/shift/compare, DATA_WIDTH-cycle shift-add MULT.
// Registered result and flags with a one-cycle DONE pulse per accepted operation.
module ula_seq_unit #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned SIGNED_OPS = 0
) (
    input  logic                  clk,
    input  logic                  RST_N,
    input  logic [DATA_WIDTH-1:0] OP_A_IN,
    input  logic [DATA_WIDTH-1:0] OP_B_IN,
    input  logic [3:0]            SEL_ULA_IN,
    input  logic                  START_IN,
    output logic                  BUSY_OUT,
    output logic                  DONE_OUT,
    output logic [DATA_WIDTH-1:0] RESULT_OUT,
    output logic                  COMP_OUT,
    output logic                  OVERFLOW_OUT,
    output logic                  ZERO_OUT
);

    localparam int unsigned SH_W  = $clog2(DATA_WIDTH) + 1;
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
    localparam int unsigned PW    = 2 * DATA_WIDTH;
    localparam int unsigned MSB   = DATA_WIDTH - 1;

    localparam logic [SH_W-1:0]  ShLimit  = SH_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CntStart = CNT_W'(DATA_WIDTH - 1);

    localparam logic [3:0] OpAdd    = 4'h0;
    localparam logic [3:0] OpSub    = 4'h1;
    localparam logic [3:0] OpMult   = 4'h2;
    localparam logic [3:0] OpLshift = 4'h3;
    localparam logic [3:0] OpRshift = 4'h4;
    localparam logic [3:0] OpOr     = 4'h5;
    localparam logic [3:0] OpAnd    = 4'h6;
    localparam logic [3:0] OpXor    = 4'h7;
    localparam logic [3:0] OpNot    = 4'h8;
    localparam logic [3:0] OpEq     = 4'h9;
    localparam logic [3:0] OpNe     = 4'hA;
    localparam logic [3:0] OpGt     = 4'hB;
    localparam logic [3:0] OpLt     = 4'hC;
    localparam logic [3:0] OpGe     = 4'hD;
    localparam logic [3:0] OpLe     = 4'hE;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StMult
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [3:0]            sel_q, sel_d;
    logic [PW-1:0]         mcand_q, mcand_d;
    logic [PW-1:0]         acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  comp_q, comp_d;
    logic                  ovf_q, ovf_d;
    logic                  zero_q, zero_d;
    logic                  done_q, done_d;

    // Single-cycle datapath, operating on the latched operands
    logic [DATA_WIDTH:0]   add_w;
    logic [DATA_WIDTH:0]   sub_w;
    logic                  add_sovf;
    logic                  sub_sovf;
    logic [SH_W-1:0]       sh_amt;
    logic                  sh_big;
    logic [PW-1:0]         shl_w;
    logic [DATA_WIDTH-1:0] shr_w;
    logic                  eq;
    logic                  lt;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_comp;
    logic                  alu_ovf;
    logic [PW-1:0]         acc_step;

    assign add_w    = {1'b0, b_q} + {1'b0, a_q};
    assign sub_w    = {1'b0, b_q} - {1'b0, a_q};
    assign add_sovf = (a_q[MSB] == b_q[MSB]) && (add_w[MSB] != b_q[MSB]);
    assign sub_sovf = (a_q[MSB] != b_q[MSB]) && (sub_w[MSB] != b_q[MSB]);

    assign sh_amt = a_q[SH_W-1:0];
    assign sh_big = (sh_amt >= ShLimit);
    assign shl_w  = {{DATA_WIDTH{1'b0}}, b_q} << sh_amt;
    assign shr_w  = b_q >> sh_amt;

    assign eq = (b_q == a_q);
    assign lt = (SIGNED_OPS != 0) ? ($signed(b_q) < $signed(a_q)) : (b_q < a_q);

    always_comb begin
        alu_res  = '0;
        alu_comp = 1'b0;
        alu_ovf  = 1'b0;
        case (sel_q)
            OpAdd: begin
                alu_res = add_w[DATA_WIDTH-1:0];
                alu_ovf = (SIGNED_OPS != 0) ? add_sovf : add_w[DATA_WIDTH];
            end
            OpSub: begin
                // Bit DATA_WIDTH of the widened difference is the unsigned borrow
                alu_res = sub_w[DATA_WIDTH-1:0];
                alu_ovf = (SIGNED_OPS != 0) ? sub_sovf : sub_w[DATA_WIDTH];
            end
            OpLshift: begin
                if (sh_big) begin
                    alu_ovf = |b_q;
                end else begin
                    alu_res = shl_w[DATA_WIDTH-1:0];
                    alu_ovf = |shl_w[PW-1:DATA_WIDTH];
                end
            end
            OpRshift: begin
                if (!sh_big) begin
                    alu_res = shr_w;
                end
            end
            OpOr:  alu_res = b_q | a_q;
            OpAnd: alu_res = b_q & a_q;
            OpXor: alu_res = b_q ^ a_q;
            OpNot: alu_res = ~a_q;
            OpEq:  alu_comp = eq;
            OpNe:  alu_comp = !eq;
            OpGt:  alu_comp = !lt && !eq;
            OpLt:  alu_comp = lt;
            OpGe:  alu_comp = !lt;
            OpLe:  alu_comp = lt || eq;
            default: ;
        endcase
    end

    assign acc_step = acc_q + (b_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sel_d    = sel_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        comp_d   = comp_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (START_IN) begin
                    a_d     = OP_A_IN;
                    b_d     = OP_B_IN;
                    sel_d   = SEL_ULA_IN;
                    mcand_d = {{DATA_WIDTH{1'b0}}, OP_A_IN};
                    acc_d   = '0;
                    cnt_d   = CntStart;
                    state_d = (SEL_ULA_IN == OpMult) ? StMult : StExec;
                end
            end
            StExec: begin
                result_d = alu_res;
                comp_d   = alu_comp;
                ovf_d    = alu_ovf;
                zero_d   = (alu_res == '0);
                done_d   = 1'b1;
                state_d  = StIdle;
            end
            StMult: begin
                acc_d   = acc_step;
                mcand_d = mcand_q << 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q - CNT_W'(1);
                // Last step: the completing partial sum is committed directly
                if (cnt_q == '0) begin
                    result_d = acc_step[DATA_WIDTH-1:0];
                    comp_d   = 1'b0;
                    ovf_d    = |acc_step[PW-1:DATA_WIDTH];
                    zero_d   = (acc_step[DATA_WIDTH-1:0] == '0);
                    done_d   = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!RST_N) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            comp_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sel_q    <= sel_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            comp_q   <= comp_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign BUSY_OUT     = (state_q != StIdle);
    assign DONE_OUT     = done_q;
    assign RESULT_OUT   = result_q;
    assign COMP_OUT     = comp_q;
    assign OVERFLOW_OUT = ovf_q;
    assign ZERO_OUT     = zero_q;

endmodule
